delay_line_ctrl: RTL and testbench

Controller for a runtime-programmable, sample-count delay of configurable width. It owns a circular buffer (write pointer, read-offset addressing and fill tracking) and a request/acknowledge configuration port, so the delay can change on the fly. After every delay change it suppresses output-valid until the new delay span is populated with fresh samples. It sits between a streaming producer and consumer wherever a static delay_line is too rigid.

---
 rtl/delay_line_pkg.sv | 13 +
 rtl/delay_ram.sv | 26 ++
 rtl/delay_line_ctrl.sv | 117 +++++++++++
 tb/tb_delay_line_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the programmable delay line controller.
package delay_line_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port sample buffer: synchronous write, combinational read, array not reset.
module delay_ram
  import delay_line_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/delay_line_ctrl.sv
// Runtime-programmable sample-count delay: circular buffer control, fill tracking
// and a request/acknowledge port for changing the delay on the fly.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned RESET_DELAY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic [ADDR_WIDTH-1:0] cfg_delay,
  input  logic                  cfg_req,
  output logic                  cfg_ack,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] cur_delay,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] RST_DELAY = ADDR_WIDTH'(RESET_DELAY);
  localparam state_t                RST_STATE = (RESET_DELAY > 0) ? ST_FILL : ST_RUN;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dval_q, dval_d;
  logic                  ack_q, ack_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] new_delay;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign rd_addr = wptr_q - cur_q;

  delay_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (din_valid),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    cur_d     = cur_q;
    dout_d    = dout_q;
    dval_d    = 1'b0;
    accept    = cfg_req & ~ack_q;
    ack_d     = accept;
    new_delay = cur_q;

    if (din_valid) begin
      wptr_d = wptr_q + ADDR_WIDTH'(1);
      dout_d = (cur_q == '0) ? din : rd_data;
      unique case (state_q)
        ST_RUN:  dval_d = 1'b1;
        ST_FILL: begin
          if (fill_q == cur_q) begin
            state_d = ST_RUN;
            dval_d  = 1'b1;
          end else begin
            fill_d  = fill_q + ADDR_WIDTH'(1);
          end
        end
        default: dval_d = 1'b0;
      endcase
    end

    // The accept-cycle sample above used the old delay/state; a new epoch overrides what it set.
    if (accept || flush) begin
      new_delay = accept ? cfg_delay : cur_q;
      cur_d     = new_delay;
      fill_d    = '0;
      state_d   = (new_delay == '0) ? ST_RUN : ST_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      wptr_q  <= '0;
      fill_q  <= '0;
      cur_q   <= RST_DELAY;
      dout_q  <= '0;
      dval_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      cur_q   <= cur_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      ack_q   <= ack_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dval_q;
  assign cfg_ack    = ack_q;
  assign cur_delay  = cur_q;
  assign busy       = (state_q == ST_FILL);

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl against a sample-history reference model.
module tb_delay_line_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RD = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [AW-1:0] cfg_delay;
  logic          cfg_req;
  logic          cfg_ack;
  logic          flush;
  logic [AW-1:0] cur_delay;
  logic          busy;

  delay_line_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESET_DELAY(RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .cfg_delay (cfg_delay),
    .cfg_req   (cfg_req),
    .cfg_ack   (cfg_ack),
    .flush     (flush),
    .cur_delay (cur_delay),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: full history of valid samples, plus the count of samples
  // seen since the current delay epoch began.
  logic [DW-1:0] hist[$];
  int            m_delay;
  int            m_epoch_n;
  bit            m_ack_prev;
  bit            exp_valid;
  logic [DW-1:0] exp_dout;
  bit            exp_ack;
  bit            exp_busy;
  int            exp_cur;

  task automatic model_reset();
    m_delay    = RD;
    m_epoch_n  = 0;
    m_ack_prev = 1'b0;
    exp_valid  = 1'b0;
    exp_dout   = '0;
    exp_ack    = 1'b0;
    exp_busy   = (RD > 0);
    exp_cur    = RD;
  endtask

  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit req,
                            input int dly, input bit fl);
    bit acc;
    int g;
    acc = req && !m_ack_prev;
    if (v) begin
      g = hist.size();
      exp_valid = (m_epoch_n >= m_delay);
      if (exp_valid) exp_dout = (m_delay == 0) ? d : hist[g - m_delay];
      hist.push_back(d);
      m_epoch_n++;
    end else begin
      exp_valid = 1'b0;
    end
    exp_ack    = acc;
    m_ack_prev = acc;
    if (acc) begin
      m_delay   = dly;
      m_epoch_n = 0;
    end else if (fl) begin
      m_epoch_n = 0;
    end
    exp_busy = (m_delay > 0) && (m_epoch_n <= m_delay);
    exp_cur  = m_delay;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit req,
                      input int dly, input bit fl);
    din       = d;
    din_valid = v;
    cfg_req   = req;
    cfg_delay = AW'(dly);
    flush     = fl;
    @(posedge clk);
    model_edge(v, d, req, dly, fl);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 1'b0; cfg_req = 1'b0; cfg_delay = '0; flush = 1'b0;
    model_reset();
    #1;
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset.dout got %0h want 0", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset.valid got %0b want 0", dout_valid); end
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL reset.ack got %0b want 0", cfg_ack); end
    checks++; if (cur_delay !== AW'(RD)) begin errors++; $display("FAIL reset.cur got %0d want %0d", cur_delay, RD); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset.busy got %0b want 1", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill_reset_delay();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, DW'(i), 1'b0, 0, 1'b0);
      checks++; if (dout_valid !== exp_valid) begin errors++; $display("FAIL fill.valid n=%0d got %0b want %0b", i, dout_valid, exp_valid); end
      if (exp_valid) begin checks++; if (dout !== exp_dout) begin errors++; $display("FAIL fill.dout n=%0d got %0d want %0d", i, dout, exp_dout); end end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL fill.busy n=%0d got %0b want %0b", i, busy, exp_busy); end
      checks++; if (cfg_ack !== exp_ack) begin errors++; $display("FAIL fill.ack n=%0d got %0b want %0b", i, cfg_ack, exp_ack); end
    end
    // Sample 4 is the first valid output and carries sample 1.
    checks++; if (hist.size() >= 4 && hist[3] == DW'(4) && (dout !== DW'(12 - RD))) begin errors++; $display("FAIL fill.steady got %0d want %0d", dout, 12 - RD); end
  endtask

  task automatic test_d0();
    step(1'b0, '0, 1'b1, 0, 1'b0);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL d0.ack got %0b want 1", cfg_ack); end
    checks++; if (cur_delay !== '0) begin errors++; $display("FAIL d0.cur got %0d want 0", cur_delay); end
    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] d;
      d = $urandom;
      step(1'b1, d, 1'b0, 0, 1'b0);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL d0.valid i=%0d got %0b want 1", i, dout_valid); end
      checks++; if (dout !== d) begin errors++; $display("FAIL d0.dout i=%0d got %0h want %0h", i, dout, d); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL d0.busy i=%0d got %0b want 0", i, busy); end
      checks++; if (cfg_ack !== exp_ack) begin errors++; $display("FAIL d0.ack i=%0d got %0b want %0b", i, cfg_ack, exp_ack); end
    end
  endtask

  task automatic test_gapped();
    step(1'b0, '0, 1'b1, 2, 1'b0);
    checks++; if (cur_delay !== AW'(2)) begin errors++; $display("FAIL gap.cur got %0d want 2", cur_delay); end
    for (int i = 0; i < 32; i++) begin
      bit v;
      v = (i % 4 == 0) || (i % 4 == 3);
      step(v, $urandom, 1'b0, 0, 1'b0);
      checks++; if (dout_valid !== exp_valid) begin errors++; $display("FAIL gap.valid i=%0d got %0b want %0b", i, dout_valid, exp_valid); end
      if (exp_valid) begin checks++; if (dout !== exp_dout) begin errors++; $display("FAIL gap.dout i=%0d got %0h want %0h", i, dout, exp_dout); end end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL gap.busy i=%0d got %0b want %0b", i, busy, exp_busy); end
    end
  endtask

  task automatic test_change_on_fly();
    step(1'b0, '0, 1'b1, 2, 1'b0);
    for (int s = 10; s <= 30; s++) begin
      step(1'b1, DW'(s), (s == 15), 5, 1'b0);
      checks++; if (dout_valid !== exp_valid) begin errors++; $display("FAIL fly.valid s=%0d got %0b want %0b", s, dout_valid, exp_valid); end
      if (exp_valid) begin checks++; if (dout !== exp_dout) begin errors++; $display("FAIL fly.dout s=%0d got %0d want %0d", s, dout, exp_dout); end end
      checks++; if (cfg_ack !== exp_ack) begin errors++; $display("FAIL fly.ack s=%0d got %0b want %0b", s, cfg_ack, exp_ack); end
      checks++; if (cur_delay !== AW'(exp_cur)) begin errors++; $display("FAIL fly.cur s=%0d got %0d want %0d", s, cur_delay, exp_cur); end
      if (s == 15) begin checks++; if (dout !== DW'(13)) begin errors++; $display("FAIL fly.old_delay got %0d want 13", dout); end end
      if (s == 21) begin checks++; if (dout !== DW'(16) || dout_valid !== 1'b1) begin errors++; $display("FAIL fly.first_new got %0d/%0b want 16/1", dout, dout_valid); end end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, '0, 1'b1, 15, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, $urandom, 1'b0, 0, 1'b0);
      checks++; if (dout_valid !== exp_valid) begin errors++; $display("FAIL wrap.valid i=%0d got %0b want %0b", i, dout_valid, exp_valid); end
      if (exp_valid) begin checks++; if (dout !== exp_dout) begin errors++; $display("FAIL wrap.dout i=%0d got %0h want %0h", i, dout, exp_dout); end end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL wrap.busy i=%0d got %0b want %0b", i, busy, exp_busy); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, 1'b1, 7, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 0, 1'b0);
    #2;
    rst = 1'b1; cfg_req = 1'b1; flush = 1'b1; cfg_delay = AW'(9); din_valid = 1'b0;
    model_reset();
    #1;
    checks++; if (dout !== '0 || dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid.out got %0h/%0b want 0/0", dout, dout_valid); end
    checks++; if (cur_delay !== AW'(RD)) begin errors++; $display("FAIL rstmid.cur got %0d want %0d", cur_delay, RD); end
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL rstmid.ack got %0b want 0", cfg_ack); end
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, '0, 1'b1, 9, 1'b1);
    checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL rstmid.reack got %0b want 1", cfg_ack); end
    checks++; if (cur_delay !== AW'(9)) begin errors++; $display("FAIL rstmid.newcur got %0d want 9", cur_delay); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid.busy got %0b want 1", busy); end
    step(1'b0, '0, 1'b0, 0, 1'b0);
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL rstmid.ackdrop got %0b want 0", cfg_ack); end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 400; i++) begin
      bit req;
      if (hold > 0) begin req = 1'b1; hold--; end
      else begin req = 1'b0; if ($urandom_range(0, 15) == 0) hold = $urandom_range(1, 4); end
      step($urandom_range(0, 3) != 0, $urandom, req, $urandom_range(0, 15), $urandom_range(0, 30) == 0);
      checks++; if (dout_valid !== exp_valid) begin errors++; $display("FAIL rand.valid i=%0d got %0b want %0b", i, dout_valid, exp_valid); end
      if (exp_valid) begin checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rand.dout i=%0d got %0h want %0h", i, dout, exp_dout); end end
      checks++; if (cfg_ack !== exp_ack) begin errors++; $display("FAIL rand.ack i=%0d got %0b want %0b", i, cfg_ack, exp_ack); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand.busy i=%0d got %0b want %0b", i, busy, exp_busy); end
      checks++; if (cur_delay !== AW'(exp_cur)) begin errors++; $display("FAIL rand.cur i=%0d got %0d want %0d", i, cur_delay, exp_cur); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_reset_delay();
    test_d0();
    test_gapped();
    test_change_on_fly();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
